// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_t;

    localparam int         FL_W     = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {W{1'b1}})) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard sequencer: load-use bubbles, multi-cycle redirect flush,
// memory-stall freeze, and saturating event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             rd_en_ex,
    input  logic             redirect_ex,
    input  logic             stall_mem,
    output logic             hazard,
    output logic             flush,
    output logic             pc_hold,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(FLUSH_CYCLES - 1);
    localparam bit              MULTI     = (FLUSH_CYCLES > 1);

    hz_state_t       state_reg;
    hz_state_t       state_next;
    logic [FL_W-1:0] fl_left_reg;
    logic [FL_W-1:0] fl_left_next;
    logic            load_use;
    logic            hz_inc;
    logic            fl_inc;

    assign load_use = rd_en_ex && (rd_ex != REG_ZERO) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= RUN;
            fl_left_reg <= '0;
        end else begin
            state_reg   <= state_next;
            fl_left_reg <= fl_left_next;
        end
    end

    // Outputs are Mealy and also forced low while reset is held, since
    // reset must take effect without waiting for a clock edge.
    always_comb begin
        state_next   = state_reg;
        fl_left_next = fl_left_reg;
        hazard       = 1'b0;
        flush        = 1'b0;
        pc_hold      = 1'b0;
        hz_inc       = 1'b0;
        fl_inc       = 1'b0;
        if (rst) begin
            state_next   = RUN;
            fl_left_next = '0;
        end else if (stall_mem) begin
            pc_hold = 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (redirect_ex) begin
                        flush  = 1'b1;
                        fl_inc = 1'b1;
                        if (MULTI) begin
                            state_next   = FLUSH;
                            fl_left_next = FL_RELOAD;
                        end
                    end else if (load_use) begin
                        hazard  = 1'b1;
                        pc_hold = 1'b1;
                        hz_inc  = 1'b1;
                    end
                end
                FLUSH: begin
                    // IF/ID is being squashed, so load-use is irrelevant here.
                    flush = 1'b1;
                    if (redirect_ex) begin
                        fl_inc       = 1'b1;
                        fl_left_next = FL_RELOAD;
                    end else if (fl_left_reg <= FL_W'(1)) begin
                        state_next   = RUN;
                        fl_left_next = '0;
                    end else begin
                        fl_left_next = fl_left_reg - 1'b1;
                    end
                end
                default: begin
                    state_next   = RUN;
                    fl_left_next = '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hz_inc),
        .q   (hazard_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (fl_inc),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; a negedge monitor checks each cycle
// against expectations queued by the driver.
module tb_hazard_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic [4:0]       rd_ex;
    logic             rd_en_ex;
    logic             redirect_ex;
    logic             stall_mem;
    logic             hazard;
    logic             flush;
    logic             pc_hold;
    logic [CNT_W-1:0] hazard_cnt;
    logic [CNT_W-1:0] flush_cnt;

    typedef struct {
        string            name;
        logic             hz;
        logic             fl;
        logic             ph;
        logic [CNT_W-1:0] hc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rd_ex       (rd_ex),
        .rd_en_ex    (rd_en_ex),
        .redirect_ex (redirect_ex),
        .stall_mem   (stall_mem),
        .hazard      (hazard),
        .flush       (flush),
        .pc_hold     (pc_hold),
        .hazard_cnt  (hazard_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus just after a rising edge and queue the
    // outputs expected before the next rising edge.
    task automatic step(input string name, input logic r, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic en,
                        input logic redir, input logic st, input logic eh,
                        input logic ef, input logic ep, input int hc, input int fc);
        exp_t e;
        rst         = r;
        rs1_id      = a;
        rs2_id      = b;
        rd_ex       = d;
        rd_en_ex    = en;
        redirect_ex = redir;
        stall_mem   = st;
        e.name = name;
        e.hz   = eh;
        e.fl   = ef;
        e.ph   = ep;
        e.hc   = CNT_W'(hc);
        e.fc   = CNT_W'(fc);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input string field, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("t=%0t %-14s hz=%0b fl=%0b ph=%0b hcnt=%0d fcnt=%0d", $time, e.name,
                     hazard, flush, pc_hold, hazard_cnt, flush_cnt);
            chk(e.name, "hazard",     int'(hazard),     int'(e.hz));
            chk(e.name, "flush",      int'(flush),      int'(e.fl));
            chk(e.name, "pc_hold",    int'(pc_hold),    int'(e.ph));
            chk(e.name, "hazard_cnt", int'(hazard_cnt), int'(e.hc));
            chk(e.name, "flush_cnt",  int'(flush_cnt),  int'(e.fc));
        end
    end

    initial begin
        rst = 1'b1; rs1_id = '0; rs2_id = '0; rd_ex = '0;
        rd_en_ex = 1'b0; redirect_ex = 1'b0; stall_mem = 1'b0;
        @(posedge clk);
        #1;
        //    name            rst rs1 rs2 rd en rdr stl  hz fl ph  hc fc
        step("reset",         1,  5,  0,  5, 1, 1,  0,   0, 0, 0,  0, 0);
        step("load_use",      0,  5,  0,  5, 1, 0,  0,   1, 0, 1,  0, 0);
        step("lu_next",       0,  5,  0,  5, 0, 0,  0,   0, 0, 0,  1, 0);
        step("reg_zero",      0,  3,  0,  0, 1, 0,  0,   0, 0, 0,  1, 0);
        step("non_load",      0,  7,  0,  7, 0, 0,  0,   0, 0, 0,  1, 0);
        step("lu_rs2",        0,  1,  9,  9, 1, 0,  0,   1, 0, 1,  1, 0);
        step("redir_lu",      0,  4,  0,  4, 1, 1,  0,   0, 1, 0,  2, 0);
        step("flush2_lu",     0,  4,  0,  4, 1, 0,  0,   0, 1, 0,  2, 1);
        step("after_flush",   0,  0,  0,  0, 0, 0,  0,   0, 0, 0,  2, 1);
        step("redir_b",       0,  0,  0,  0, 0, 1,  0,   0, 1, 0,  2, 1);
        step("stall_1",       0,  8,  0,  8, 1, 1,  1,   0, 0, 1,  2, 2);
        step("stall_2",       0,  0,  0,  0, 0, 0,  1,   0, 0, 1,  2, 2);
        step("stall_3",       0,  0,  0,  0, 0, 0,  1,   0, 0, 1,  2, 2);
        step("flush_resume",  0,  0,  0,  0, 0, 0,  0,   0, 1, 0,  2, 2);
        step("run_again",     0,  0,  0,  0, 0, 0,  0,   0, 0, 0,  2, 2);
        step("lu_10",         0, 10,  0, 10, 1, 0,  0,   1, 0, 1,  2, 2);
        step("lu_11",         0, 11,  0, 11, 1, 0,  0,   1, 0, 1,  3, 2);
        step("lu_12",         0,  0, 12, 12, 1, 0,  0,   1, 0, 1,  4, 2);
        step("stall_lu",      0,  6,  0,  6, 1, 0,  1,   0, 0, 1,  5, 2);
        step("redir_c",       0,  0,  0,  0, 0, 1,  0,   0, 1, 0,  5, 2);
        step("rst_mid_flush", 1,  0,  0,  0, 0, 1,  0,   0, 0, 0,  0, 0);
        step("rst_hold",      1,  2,  0,  2, 1, 0,  1,   0, 0, 0,  0, 0);
        step("post_rst",      0,  0,  0,  0, 0, 0,  0,   0, 0, 0,  0, 0);
        step("redir_d",       0,  0,  0,  0, 0, 1,  0,   0, 1, 0,  0, 0);
        step("reredir",       0,  0,  0,  0, 0, 1,  0,   0, 1, 0,  0, 1);
        step("reredir_tail",  0,  0,  0,  0, 0, 0,  0,   0, 1, 0,  0, 2);
        step("run_end",       0,  0,  0,  0, 0, 0,  0,   0, 0, 0,  0, 2);
        done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(done && sb.size() == 0) && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        n_cmp++;
        if (sb.size() != 0 || !done) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
